// File: rtl/matmul_2x2_seq.sv
// Sequential 2x2 unsigned matrix multiplier: C = A x B through one shared MAC, 8 products per run.
// Optional macro MATMUL_SAT_EN selects saturating element writeback instead of modulo-2^DW truncation.
module matmul_2x2_seq #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] a11,
    input  logic [DW-1:0] a12,
    input  logic [DW-1:0] a21,
    input  logic [DW-1:0] a22,
    input  logic [DW-1:0] b11,
    input  logic [DW-1:0] b12,
    input  logic [DW-1:0] b21,
    input  logic [DW-1:0] b22,
    output logic [DW-1:0] c11,
    output logic [DW-1:0] c12,
    output logic [DW-1:0] c21,
    output logic [DW-1:0] c22,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned IW = 3;
    localparam logic [SW-1:0] ELEM_MAX = SW'({DW{1'b1}});
    localparam logic [IW-1:0] IDX_LAST = IW'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [PW-1:0] acc;
    logic [DW-1:0] a_q [4];
    logic [DW-1:0] b_q [4];
    logic [DW-1:0] c_q [4];

    logic          accept;
    logic          busy_nxt;
    logic          done_nxt;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;
    logic          sum_ovf;
    logic [DW-1:0] elem;

    // Operand select: A row = idx[2], k = idx[0]; B column = idx[1]; element = idx[2:1]
    always_comb begin
        op_a    = a_q[{idx[2], idx[0]}];
        op_b    = b_q[{idx[0], idx[1]}];
        prod    = PW'(op_a) * PW'(op_b);
        sum     = SW'(acc) + SW'(prod);
        sum_ovf = (sum > ELEM_MAX);
`ifdef MATMUL_SAT_EN
        elem    = sum_ovf ? {DW{1'b1}} : sum[DW-1:0];
`else
        elem    = sum[DW-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (idx == IDX_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; busy/done are registered from the upcoming state
    always_comb begin
        accept   = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state == IDLE && start) accept = 1'b1;
        if (state_nxt != IDLE) busy_nxt = 1'b1;
        if (state_nxt == DONE) done_nxt = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            acc  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (accept) begin
                a_q[0] <= a11;
                a_q[1] <= a12;
                a_q[2] <= a21;
                a_q[3] <= a22;
                b_q[0] <= b11;
                b_q[1] <= b12;
                b_q[2] <= b21;
                b_q[3] <= b22;
                acc    <= '0;
                idx    <= '0;
                ovf    <= 1'b0;
            end else if (state == MAC) begin
                idx <= IW'(idx + IW'(1));
                if (!idx[0]) begin
                    acc <= prod;
                end else begin
                    c_q[idx[2:1]] <= elem;
                    acc           <= '0;
                    if (sum_ovf) ovf <= 1'b1;
                end
            end
        end
    end

    assign c11 = c_q[0];
    assign c12 = c_q[1];
    assign c21 = c_q[2];
    assign c22 = c_q[3];

endmodule

// File: tb/tb_matmul_2x2_seq.sv
// Directed self-checking bench for matmul_2x2_seq; honours MATMUL_SAT_EN when defined for the build.
module tb_matmul_2x2_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] a11, a12, a21, a22;
    logic [7:0] b11, b12, b21, b22;
    logic [7:0] c11, c12, c21, c22;
    logic       busy, done, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_2x2_seq #(.DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .busy(busy), .done(done), .ovf(ovf)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag, input int e11, input int e12, input int e21, input int e22);
        check({tag, "_c11"}, int'(c11), e11);
        check({tag, "_c12"}, int'(c12), e12);
        check({tag, "_c21"}, int'(c21), e21);
        check({tag, "_c22"}, int'(c22), e22);
    endtask

    task automatic set_ops(input logic [7:0] x11, input logic [7:0] x12, input logic [7:0] x21,
                           input logic [7:0] x22, input logic [7:0] y11, input logic [7:0] y12,
                           input logic [7:0] y21, input logic [7:0] y22);
        a11 = x11; a12 = x12; a21 = x21; a22 = x22;
        b11 = y11; b12 = y12; b21 = y21; b22 = y22;
    endtask

    // Pulse start for one edge; returns half a cycle after the accepting edge
    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int dones;
        int first_k;
        int second_k;
        int sat_exp;

        reset_n = 1'b0;
        start   = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_c("rst", 0, 0, 0, 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(ovf), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic run with per-edge timing
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        kick();
        check("basic_busy_e0", int'(busy), 1);
        check("basic_done_e0", int'(done), 0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) check("basic_c11_e1", int'(c11), 0);
            if (k == 2) begin
                check("basic_c11_e2", int'(c11), 19);
                check("basic_c12_e2", int'(c12), 0);
            end
            if (k == 4) check("basic_c12_e4", int'(c12), 22);
            if (k == 6) check("basic_c21_e6", int'(c21), 43);
            if (k == 7) check("basic_done_e7", int'(done), 0);
            if (k == 8) begin
                check("basic_done_e8", int'(done), 1);
                check("basic_c22_e8", int'(c22), 50);
                check("basic_ovf", int'(ovf), 0);
                check("basic_busy_e8", int'(busy), 1);
            end
            if (k == 9) begin
                check("basic_done_e9", int'(done), 0);
                check("basic_busy_e9", int'(busy), 0);
            end
        end

        // All-255 operands: every element sum is 130050
`ifdef MATMUL_SAT_EN
        sat_exp = 255;
`else
        sat_exp = 2;
`endif
        set_ops(255, 255, 255, 255, 255, 255, 255, 255);
        kick();
        wait_done(cyc);
        check("ovf_latency", cyc, 8);
        check_c("ovf", sat_exp, sat_exp, sat_exp, sat_exp);
        check("ovf_flag", int'(ovf), 1);
        @(negedge clk);
        check("ovf_hold", int'(ovf), 1);
        check("ovf_done_low", int'(done), 0);

        // start while busy is ignored; operands changed after acceptance don't matter
        set_ops(2, 0, 0, 2, 3, 4, 5, 6);
        kick();
        check("ign_ovf_clr", int'(ovf), 0);
        set_ops(9, 9, 9, 9, 9, 9, 9, 9);
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) start = 1'b1;
            if (k == 3) begin
                start = 1'b0;
                check("ign_busy_e3", int'(busy), 1);
            end
            if (k == 8) check("ign_busy_e8", int'(busy), 1);
            if (done) dones++;
        end
        check("ign_busy_end", int'(busy), 0);
        check("ign_dones", dones, 1);
        check_c("ign", 6, 8, 10, 12);

        // Asynchronous reset in the middle of a run
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        kick();
        repeat (4) @(negedge clk);
        check("mid_c11_pre", int'(c11), 19);
        reset_n = 1'b0;
        #1;
        check_c("mid_rst", 0, 0, 0, 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_idle_busy", int'(busy), 0);
        set_ops(1, 0, 0, 1, 9, 8, 7, 6);
        kick();
        wait_done(cyc);
        check("ident_latency", cyc, 8);
        check_c("ident", 9, 8, 7, 6);

        // Back-to-back with start held: second acceptance at E10
        @(negedge clk);
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        start = 1'b1;
        @(negedge clk);
        a11 = 0; a12 = 0; a21 = 0; a22 = 0;
        dones    = 0;
        first_k  = -1;
        second_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first_k < 0) first_k = k;
                else second_k = k;
            end
            if (k == 8) check_c("b2b_first", 19, 22, 43, 50);
            if (k == 9) check("b2b_busy_e9", int'(busy), 0);
            if (k == 10) begin
                check("b2b_busy_e10", int'(busy), 1);
                start = 1'b0;
            end
            if (k == 18) begin
                check_c("b2b_second", 0, 0, 0, 0);
                check("b2b_ovf", int'(ovf), 0);
            end
        end
        check("b2b_dones", dones, 2);
        check("b2b_first_done", first_k, 8);
        check("b2b_second_done", second_k, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
